// File: rtl/qk_input_stager_pkg.sv
// Shared constants and state encoding for the Q/K input stager and its row packer.
package qk_input_stager_pkg;

    localparam int unsigned BW          = 8;
    localparam int unsigned PR          = 16;
    localparam int unsigned TOTAL_CYCLE = 8;
    localparam int unsigned COL         = 8;
    localparam int unsigned START_LAT   = 2;

    localparam int unsigned NROWS = TOTAL_CYCLE + COL;
    localparam int unsigned ROW_W = PR * BW;

    typedef logic [1:0] state_t;

    localparam state_t FILL   = 2'd0;
    localparam state_t LAUNCH = 2'd1;
    localparam state_t WAIT   = 2'd2;
    localparam state_t STREAM = 2'd3;

    // Counter width for n states, never narrower than one bit.
    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/qk_input_stager_row_packer.sv
// Packs a byte stream into pr-byte rows, first byte in the LSBs; row_done flags the
// transfer that completes a row, with the full row presented alongside it.
module row_packer
    import qk_input_stager_pkg::*;
#(
    parameter int unsigned bw = BW,
    parameter int unsigned pr = PR
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [bw-1:0]     in_byte,
    input  logic              in_valid,
    output logic              row_done,
    output logic [pr*bw-1:0]  row
);

    localparam int unsigned HoldW = (pr - 1) * bw;
    localparam int unsigned CntW  = idx_width(pr);
    localparam logic [CntW-1:0] LastByte = CntW'(pr - 1);

    logic [CntW-1:0]  byte_cnt_q, byte_cnt_d;
    logic [HoldW-1:0] hold_q, hold_d;

    // Earlier bytes sit in hold_q; the incoming byte tops off the row.
    assign row      = {in_byte, hold_q};
    assign row_done = in_valid && (byte_cnt_q == LastByte);

    always_comb begin
        byte_cnt_d = byte_cnt_q;
        hold_d     = hold_q;
        if (in_valid) begin
            hold_d     = HoldW'(row >> bw);
            byte_cnt_d = row_done ? '0 : byte_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            byte_cnt_q <= '0;
        end else begin
            byte_cnt_q <= byte_cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        hold_q <= hold_d;
    end

endmodule

// File: rtl/qk_input_stager.sv
// Buffers one batch of Q then K rows from a byte stream, pulses start, and replays the rows
// on mem_in one per cycle beginning start_lat cycles after the start pulse.
module qk_input_stager
    import qk_input_stager_pkg::*;
#(
    parameter int unsigned bw          = BW,
    parameter int unsigned pr          = PR,
    parameter int unsigned total_cycle = TOTAL_CYCLE,
    parameter int unsigned col         = COL,
    parameter int unsigned start_lat   = START_LAT
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [bw-1:0]     in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic              start,
    output logic [pr*bw-1:0]  mem_in,
    output logic              row_valid,
    output logic              busy
);

    localparam int unsigned RowW = pr * bw;
    localparam int unsigned Rows = total_cycle + col;
    localparam int unsigned IdxW = idx_width(Rows);
    localparam logic [IdxW-1:0] LastRow = IdxW'(Rows - 1);
    localparam logic [3:0] DlyInit = (start_lat > 1) ? 4'(start_lat - 2) : 4'd0;

    state_t          state_q, state_d;
    logic [IdxW-1:0] row_cnt_q, row_cnt_d;
    logic [IdxW-1:0] rd_idx_q, rd_idx_d;
    logic [3:0]      dly_cnt_q, dly_cnt_d;
    logic            in_ready_q, start_q, row_valid_q, busy_q;
    logic [RowW-1:0] mem_in_q, mem_in_d;
    logic [RowW-1:0] row_buf_q [Rows];

    logic            xfer;
    logic            row_done;
    logic [RowW-1:0] packed_row;

    // in_ready_q is high exactly in FILL, so it alone qualifies a transfer.
    assign xfer = in_valid && in_ready_q;

    row_packer #(
        .bw (bw),
        .pr (pr)
    ) u_row_packer (
        .clk      (clk),
        .reset    (reset),
        .in_byte  (in_data),
        .in_valid (xfer),
        .row_done (row_done),
        .row      (packed_row)
    );

    always_comb begin
        state_d   = state_q;
        row_cnt_d = row_cnt_q;
        rd_idx_d  = rd_idx_q;
        dly_cnt_d = dly_cnt_q;
        unique case (state_q)
            FILL: begin
                if (row_done) begin
                    if (row_cnt_q == LastRow) begin
                        state_d   = LAUNCH;
                        row_cnt_d = '0;
                    end else begin
                        row_cnt_d = row_cnt_q + 1'b1;
                    end
                end
            end
            LAUNCH: begin
                rd_idx_d = '0;
                if (start_lat > 1) begin
                    state_d   = WAIT;
                    dly_cnt_d = DlyInit;
                end else begin
                    state_d = STREAM;
                end
            end
            WAIT: begin
                if (dly_cnt_q == 4'd0) begin
                    state_d  = STREAM;
                    rd_idx_d = '0;
                end else begin
                    dly_cnt_d = dly_cnt_q - 4'd1;
                end
            end
            STREAM: begin
                if (rd_idx_q == LastRow) begin
                    state_d  = FILL;
                    rd_idx_d = '0;
                end else begin
                    rd_idx_d = rd_idx_q + 1'b1;
                end
            end
            default: state_d = FILL;
        endcase
    end

    // Outputs are registered from next state so row r lands in the cycle of its STREAM slot.
    assign mem_in_d = (state_d == STREAM) ? row_buf_q[rd_idx_d] : '0;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= FILL;
            row_cnt_q   <= '0;
            rd_idx_q    <= '0;
            dly_cnt_q   <= '0;
            in_ready_q  <= 1'b0;
            start_q     <= 1'b0;
            mem_in_q    <= '0;
            row_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            row_cnt_q   <= row_cnt_d;
            rd_idx_q    <= rd_idx_d;
            dly_cnt_q   <= dly_cnt_d;
            in_ready_q  <= (state_d == FILL);
            start_q     <= (state_d == LAUNCH);
            mem_in_q    <= mem_in_d;
            row_valid_q <= (state_d == STREAM);
            busy_q      <= (state_d != FILL);
        end
    end

    // Buffer is never cleared; every row is rewritten before it is streamed.
    always_ff @(posedge clk) begin
        if (row_done) begin
            row_buf_q[row_cnt_q] <= packed_row;
        end
    end

    assign in_ready  = in_ready_q;
    assign start     = start_q;
    assign mem_in    = mem_in_q;
    assign row_valid = row_valid_q;
    assign busy      = busy_q;

endmodule
